// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode constants (instruction bits [6:2]),
// the immediate-format select consumed by the immediate extender and the EX
// operand muxes, the canonical NOP, and the decode-slot state encoding.
package riscv_pkg;

  // Major opcodes, bits [6:2] of the instruction (bits [1:0] are always 2'b11).
  localparam logic [4:0] R_TYPE  = 5'b01100;
  localparam logic [4:0] I_COMP  = 5'b00100;
  localparam logic [4:0] I_LOAD  = 5'b00000;
  localparam logic [4:0] I_JALR  = 5'b11001;
  localparam logic [4:0] STORE   = 5'b01000;
  localparam logic [4:0] B_TYPE  = 5'b11000;
  localparam logic [4:0] U_LUI   = 5'b01101;
  localparam logic [4:0] U_AUIPC = 5'b00101;
  localparam logic [4:0] J_JAL   = 5'b11011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Immediate format select; value 6 is unused, 7 flags an unsupported opcode.
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } imm_fmt_t;

  // Occupancy of the IF/ID slot.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HAZARD = 2'd2
  } dec_state_t;

endpackage

// File: rtl/decode_fmt.sv
// Opcode classifier: maps instruction bits [6:2] to the immediate format and
// to which source-register fields are actually read. Purely combinational so
// the immediate extender select can share it.
module decode_fmt
  import riscv_pkg::*;
(
  input  logic [4:0] opcode,
  output imm_fmt_t   fmt,
  output logic       illegal,
  output logic       rs1_used,
  output logic       rs2_used
);

  // Format lookup; register usage follows from the format.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    fmt      = FMT_ILL;
    illegal  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      R_TYPE: begin
        fmt      = FMT_R;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      I_COMP, I_LOAD, I_JALR: begin
        fmt      = FMT_I;
        rs1_used = 1'b1;
      end
      STORE: begin
        fmt      = FMT_S;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      B_TYPE: begin
        fmt      = FMT_B;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      U_LUI, U_AUIPC: begin
        fmt = FMT_U;
      end
      J_JAL: begin
        fmt = FMT_J;
      end
      default: begin
        fmt     = FMT_ILL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage sequencer: owns the IF/ID slot, handshakes with fetch and
// execute, inserts a single bubble on a load-use hazard against EX and drops
// the slot on a branch/jump flush.
// Build option: define DECODE_CTRL_PERF_EN to instantiate the stall_cycles
// counter; otherwise the port is tied to zero.
module decode_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        ex_ready,
  input  logic        ex_load_valid,
  input  logic [4:0]  ex_load_rd,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [2:0]  id_fmt,
  output logic        id_illegal,
  output logic [31:0] stall_cycles
);

  dec_state_t  state;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  imm_fmt_t    fmt;
  logic        illegal;
  logic        rs1_used;
  logic        rs2_used;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        hazard;

  decode_fmt u_decode_fmt (
    .opcode   (inst_q[6:2]),
    .fmt      (fmt),
    .illegal  (illegal),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign id_inst    = inst_q;
  assign id_pc      = pc_q;
  assign id_fmt     = fmt;
  assign id_illegal = illegal;

  // Load-use check: only sources the held instruction really reads count, and
  // a load into x0 never produces a dependency.
  always_comb begin
    rs1_hit = rs1_used && (inst_q[19:15] == ex_load_rd);
    rs2_hit = rs2_used && (inst_q[24:20] == ex_load_rd);
    hazard  = (state == ST_FULL) && ex_load_valid && (ex_load_rd != 5'd0)
              && (rs1_hit || rs2_hit);
  end

  // Handshake outputs: flush silences both sides regardless of state.
  always_comb begin
    id_valid = 1'b0;
    if_ready = 1'b0;
    if (!flush) begin
      unique case (state)
        ST_EMPTY: begin
          if_ready = 1'b1;
        end
        ST_FULL: begin
          if (!hazard) begin
            id_valid = 1'b1;
            if_ready = ex_ready;
          end
        end
        default: begin
          id_valid = 1'b0;
          if_ready = 1'b0;
        end
      endcase
    end
  end

  // Slot state and contents: reset beats flush, flush beats the handshake.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      // NOTE: the slot contents are reset too, so id_inst shows a clean NOP
      // and id_pc zero straight out of reset instead of X.
      state  <= ST_EMPTY;
      inst_q <= NOP;
      pc_q   <= '0;
    end else if (flush) begin
      state  <= ST_EMPTY;
      inst_q <= NOP;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (if_valid) begin
            inst_q <= if_inst;
            pc_q   <= if_pc;
            state  <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (hazard) begin
            state <= ST_HAZARD;
          end else if (ex_ready) begin
            if (if_valid) begin
              inst_q <= if_inst;
              pc_q   <= if_pc;
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        ST_HAZARD: begin
          // One bubble only; the load has moved on by the next cycle.
          state <= ST_FULL;
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef DECODE_CTRL_PERF_EN
  logic perf_stall;

  // A stall cycle is a bubble cycle or an offered instruction EX refuses.
  assign perf_stall = (state == ST_HAZARD)
                      || ((state == ST_FULL) && id_valid && !ex_ready);

  // Free-running stall counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (perf_stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios with literal
// expectations followed by a randomized run, all compared every cycle against
// a slot-occupancy reference model.
`timescale 1ns/1ps
module tb_decode_ctrl;

`ifdef DECODE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_ready;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [2:0]  id_fmt;
  logic        id_illegal;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  decode_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_ready      (if_ready),
    .ex_ready      (ex_ready),
    .ex_load_valid (ex_load_valid),
    .ex_load_rd    (ex_load_rd),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_fmt        (id_fmt),
    .id_illegal    (id_illegal),
    .stall_cycles  (stall_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The slot either holds nothing, or holds an instruction that may be
  // serving its one-cycle load-use bubble.
  bit          m_occ;
  bit          m_bub;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic [31:0] m_stall;

  // Format straight from the opcode table.
  function automatic int fmt_of(input logic [31:0] inst);
    logic [4:0] op;
    op = inst[6:2];
    case (op)
      5'b01100:                   return 0;
      5'b00100, 5'b00000, 5'b11001: return 1;
      5'b01000:                   return 2;
      5'b11000:                   return 3;
      5'b01101, 5'b00101:         return 4;
      5'b11011:                   return 5;
      default:                    return 7;
    endcase
  endfunction

  function automatic bit reads_rs1(input int f);
    return (f <= 3);
  endfunction

  function automatic bit reads_rs2(input int f);
    return (f == 0) || (f == 2) || (f == 3);
  endfunction

  function automatic bit m_hazard();
    int f;
    f = fmt_of(m_inst);
    if (!m_occ || m_bub || !ex_load_valid || ex_load_rd == 5'd0) return 1'b0;
    return (reads_rs1(f) && m_inst[19:15] == ex_load_rd) ||
           (reads_rs2(f) && m_inst[24:20] == ex_load_rd);
  endfunction

  function automatic bit m_valid();
    return !flush && m_occ && !m_bub && !m_hazard();
  endfunction

  function automatic bit m_ready();
    if (flush) return 1'b0;
    if (!m_occ) return 1'b1;
    return !m_bub && !m_hazard() && ex_ready;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_occ = 0; m_bub = 0; m_inst = NOP_I; m_pc = '0; m_stall = '0;
    end else begin
      bit hz, v;
      hz = m_hazard();
      v  = m_valid();
      if (m_bub || (v && !ex_ready)) m_stall = m_stall + 32'd1;
      if (flush) begin
        m_occ = 0; m_bub = 0; m_inst = NOP_I;
      end else if (m_bub) begin
        m_bub = 0;
      end else if (!m_occ) begin
        if (if_valid) begin m_occ = 1; m_inst = if_inst; m_pc = if_pc; end
      end else if (hz) begin
        m_bub = 1;
      end else if (ex_ready) begin
        if (if_valid) begin m_inst = if_inst; m_pc = if_pc; end
        else m_occ = 0;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int f;
      f = fmt_of(m_inst);
      check("id_valid",   {31'd0, id_valid},   {31'd0, m_valid()});
      check("if_ready",   {31'd0, if_ready},   {31'd0, m_ready()});
      check("id_inst",    id_inst,             m_inst);
      check("id_pc",      id_pc,               m_pc);
      check("id_fmt",     {29'd0, id_fmt},     f);
      check("id_illegal", {31'd0, id_illegal}, {31'd0, (f == 7)});
      check("stall",      stall_cycles,        PERF ? m_stall : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic exr, input logic lv, input logic [4:0] lrd,
                      input logic fl, input logic rn);
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    if_valid = v; if_inst = inst; if_pc = pc; ex_ready = exr;
    ex_load_valid = lv; ex_load_rd = lrd; flush = fl; rst_n = rn;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] ops [11];
    logic [4:0] op;
    ops = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000, 5'b11000,
            5'b01101, 5'b00101, 5'b11011, 5'b11111, 5'b11100};
    op = ops[$urandom_range(0, 10)];
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom), op, 2'b11};
  endfunction

  logic [31:0] snap;

  initial begin
    rst_n = 0; if_valid = 0; if_inst = 0; if_pc = 0; ex_ready = 0;
    ex_load_valid = 0; ex_load_rd = 0; flush = 0;

    // Reset values.
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("rst_inst",  id_inst, NOP_I);
    check("rst_pc",    id_pc, 32'h0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_ready", {31'd0, if_ready}, 32'd1);
    check("rst_stall", stall_cycles, 32'd0);

    // Back-to-back addi, sw, beq.
    step(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    check("b2b_ready0", {31'd0, if_ready}, 32'd1);
    step(1'b1, 32'h0011_2023, 32'h104, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    check("b2b_v1",   {31'd0, id_valid}, 32'd1);
    check("b2b_fmt1", {29'd0, id_fmt}, 32'd1);
    check("b2b_rdy1", {31'd0, if_ready}, 32'd1);
    step(1'b1, 32'h0020_8463, 32'h108, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    check("b2b_fmt2", {29'd0, id_fmt}, 32'd2);
    check("b2b_pc2",  id_pc, 32'h104);
    idle();
    check("b2b_fmt3", {29'd0, id_fmt}, 32'd3);
    check("b2b_v3",   {31'd0, id_valid}, 32'd1);
    idle();
    check("b2b_drain", {31'd0, id_valid}, 32'd0);

    // Load-use on add x3,x1,x2 against a load to x1.
    step(1'b1, 32'h0020_81B3, 32'h200, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    check("lu_detect_v", {31'd0, id_valid}, 32'd0);
    check("lu_detect_r", {31'd0, if_ready}, 32'd0);
    idle();
    check("lu_bubble_v", {31'd0, id_valid}, 32'd0);
    idle();
    check("lu_issue_v",  {31'd0, id_valid}, 32'd1);
    check("lu_issue_i",  id_inst, 32'h0020_81B3);
    check("lu_stall",    stall_cycles, PERF ? 32'd1 : 32'd0);
    idle();

    // Load into x0: no bubble.
    step(1'b1, 32'h0020_81B3, 32'h210, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    check("x0_nobub", {31'd0, id_valid}, 32'd1);
    // lui x5,0xF: rs1 field equals 1 but is not read.
    step(1'b1, 32'h0000_F2B7, 32'h220, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    check("lui_nobub", {31'd0, id_valid}, 32'd1);
    check("lui_fmt",   {29'd0, id_fmt}, 32'd4);
    idle();

    // EX back-pressure for three cycles.
    step(1'b1, 32'h0050_0093, 32'h300, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 32'h0011_2023, 32'h304, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    snap = stall_cycles;
    step(1'b1, 32'h0011_2023, 32'h304, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 32'h0011_2023, 32'h304, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    check("bp_inst",  id_inst, 32'h0050_0093);
    check("bp_pc",    id_pc, 32'h300);
    check("bp_ready", {31'd0, if_ready}, 32'd0);
    idle();
    check("bp_stall", stall_cycles - snap, PERF ? 32'd3 : 32'd0);
    idle();

    // Flush while FULL with a fetch offered.
    step(1'b1, 32'h0020_8463, 32'h400, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 32'h00A0_0513, 32'h404, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    check("fl_valid", {31'd0, id_valid}, 32'd0);
    idle();
    check("fl_inst",  id_inst, NOP_I);
    check("fl_empty", {31'd0, id_valid}, 32'd0);
    idle();
    check("fl_gone",  {31'd0, id_valid}, 32'd0);

    // Illegal opcode still issues.
    step(1'b1, 32'h0000_007F, 32'h500, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    idle();
    check("ill_fmt",   {29'd0, id_fmt}, 32'd7);
    check("ill_flag",  {31'd0, id_illegal}, 32'd1);
    check("ill_valid", {31'd0, id_valid}, 32'd1);
    idle();

    // Reset during the bubble.
    step(1'b1, 32'h0020_81B3, 32'h600, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    check("rh_inst",  id_inst, NOP_I);
    check("rh_pc",    id_pc, 32'h0);
    check("rh_valid", {31'd0, id_valid}, 32'd0);
    check("rh_ready", {31'd0, if_ready}, 32'd1);
    check("rh_stall", stall_cycles, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_inst(), 32'($urandom) & ~32'h3,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 199) != 0));
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
